// File: rtl/outfifo_pkg.sv
// Shared definitions for the outfifo_sync processor-to-external byte FIFO.
package outfifo_pkg;

    localparam int unsigned DEFAULT_DEPTH      = 16;
    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    // Occupancy counter must hold 0..depth inclusive.
    function automatic int unsigned calc_cw(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [calc_cw(DEFAULT_DEPTH)-1:0] count_t;

endpackage

// File: rtl/outfifo_sync_ram.sv
// Register-file RAM for outfifo_sync: synchronous write, combinational read, no reset.
module outfifo_sync_ram #(
    parameter int unsigned ENTRIES    = 15,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned AW         = 4
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] mem [ENTRIES];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/outfifo_sync.sv
// Processor-to-external FWFT byte FIFO: output register plus (DEPTH-1)-entry RAM.
// Optional sticky overflow flag enabled by defining OUTFIFO_SYNC_OVERFLOW_EN.
module outfifo_sync
    import outfifo_pkg::*;
#(
    parameter int unsigned  DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned  DATA_WIDTH = DEFAULT_DATA_WIDTH,
    localparam int unsigned CW         = calc_cw(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_outport,
    input  logic                  i_outport_wr,
    output logic                  o_full,
    output logic [CW-1:0]         o_count,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_empty,
`ifdef OUTFIFO_SYNC_OVERFLOW_EN
    input  logic                  i_overflow_clr,
    output logic                  o_overflow,
`endif
    input  logic                  i_data_rd
);

    localparam int unsigned RAM_DEPTH = DEPTH - 1;
    localparam int unsigned PW        = $clog2(RAM_DEPTH);

    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, empty_q;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic wr_acc, rd_acc;
    logic wr_to_out, wr_to_ram, ram_pop;

    // RAM depth is not a power of two, so wrap with an explicit compare.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(RAM_DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    always_comb begin
        wr_acc    = i_outport_wr & ~full_q;
        rd_acc    = i_data_rd & ~empty_q;
        // Bypass the RAM when the output register is (or is about to be) free.
        wr_to_out = wr_acc & (empty_q | ((count_q == CW'(1)) & rd_acc));
        wr_to_ram = wr_acc & ~wr_to_out;
        ram_pop   = rd_acc & (count_q > CW'(1));

        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end

        wr_ptr_d = wr_to_ram ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = ram_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        data_d = data_q;
        if (ram_pop) begin
            data_d = ram_rdata;
        end else if (wr_to_out) begin
            data_d = i_outport;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            data_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == '0);
            data_q   <= data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    outfifo_sync_ram #(
        .ENTRIES    (RAM_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (PW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (wr_to_ram),
        .i_waddr (wr_ptr_q),
        .i_wdata (i_outport),
        .i_raddr (rd_ptr_q),
        .o_rdata (ram_rdata)
    );

`ifdef OUTFIFO_SYNC_OVERFLOW_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q;
        if (i_overflow_clr) begin
            overflow_d = 1'b0;
        end
        if (i_outport_wr && full_q) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign o_overflow = overflow_q;
`endif

    assign o_full       = full_q;
    assign o_count      = count_q;
    assign o_data       = data_q;
    assign o_data_empty = empty_q;

endmodule

// File: tb/tb_outfifo_sync.sv
// Self-checking bench for outfifo_sync: directed vector table, reset and random scoreboard runs.
module tb_outfifo_sync;
    import outfifo_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned DW    = 8;
    localparam int unsigned CW    = calc_cw(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] outport;
    logic          outport_wr;
    logic          full;
    logic [CW-1:0] count;
    logic [DW-1:0] data;
    logic          data_empty;
    logic          data_rd;
`ifdef OUTFIFO_SYNC_OVERFLOW_EN
    logic          overflow_clr;
    logic          overflow;
`endif

    always #5 clk = ~clk;

    outfifo_sync #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_outport      (outport),
        .i_outport_wr   (outport_wr),
        .o_full         (full),
        .o_count        (count),
        .o_data         (data),
        .o_data_empty   (data_empty),
`ifdef OUTFIFO_SYNC_OVERFLOW_EN
        .i_overflow_clr (overflow_clr),
        .o_overflow     (overflow),
`endif
        .i_data_rd      (data_rd)
    );

    typedef struct {
        logic          wr;
        logic [DW-1:0] din;
        logic          rd;
        int unsigned   cnt;
        logic          empty;
        logic          full;
        logic [DW-1:0] data;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [DW-1:0] din, input logic rd,
                                input int unsigned cnt, input logic [DW-1:0] dat);
        vec_t v;
        v.wr    = wr;
        v.din   = din;
        v.rd    = rd;
        v.cnt   = cnt;
        v.empty = (cnt == 0);
        v.full  = (cnt == DEPTH);
        v.data  = dat;
        return v;
    endfunction

    task automatic cycle(input logic wr, input logic [DW-1:0] din, input logic rd);
        @(negedge clk);
        outport_wr = wr;
        outport    = din;
        data_rd    = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   q[$];
        logic wr, rd;
        logic [DW-1:0] din;

        rst_n      = 1'b0;
        outport    = '0;
        outport_wr = 1'b0;
        data_rd    = 1'b0;
`ifdef OUTFIFO_SYNC_OVERFLOW_EN
        overflow_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_count", 32'(count), 0);
        check("reset_empty", 32'(data_empty), 1);
        check("reset_full", 32'(full), 0);
        check("reset_data", 32'(data), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // FWFT, empty read, bypass at count==1 with pop
        vecs.push_back(mk(1'b1, 8'h3C, 1'b0, 1, 8'h3C));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 0, 8'h3C));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 0, 8'h3C));
        vecs.push_back(mk(1'b1, 8'h55, 1'b0, 1, 8'h55));
        vecs.push_back(mk(1'b1, 8'h77, 1'b1, 1, 8'h77));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 0, 8'h77));
        // Burst fill, dropped write, write+pop at full, drain
        for (int i = 1; i <= 16; i++) begin
            vecs.push_back(mk(1'b1, 8'(i), 1'b0, i, 8'h01));
        end
        vecs.push_back(mk(1'b1, 8'h11, 1'b0, 16, 8'h01));
        vecs.push_back(mk(1'b1, 8'h22, 1'b1, 15, 8'h02));
        for (int k = 14; k >= 1; k--) begin
            vecs.push_back(mk(1'b0, 8'h00, 1'b1, k, 8'(17 - k)));
        end
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 0, 8'h10));

        foreach (vecs[i]) begin
            cycle(vecs[i].wr, vecs[i].din, vecs[i].rd);
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_empty", i), 32'(data_empty), 32'(vecs[i].empty));
            check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].full));
            check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].data));
        end

`ifdef OUTFIFO_SYNC_OVERFLOW_EN
        check("overflow_sticky", 32'(overflow), 1);
        @(negedge clk);
        data_rd      = 1'b0;
        outport_wr   = 1'b0;
        overflow_clr = 1'b1;
        @(posedge clk);
        #1;
        overflow_clr = 1'b0;
        check("overflow_clear", 32'(overflow), 0);
`endif

        // Asynchronous reset mid-stream with count=5
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'(8'h40 + i), 1'b0);
        end
        check("pre_reset_count", 32'(count), 5);
        @(negedge clk);
        outport_wr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(count), 0);
        check("async_rst_empty", 32'(data_empty), 1);
        check("async_rst_full", 32'(full), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 8'hA5, 1'b0);
        check("post_rst_data", 32'(data), 32'hA5);
        check("post_rst_count", 32'(count), 1);
        check("post_rst_empty", 32'(data_empty), 0);
        cycle(1'b0, 8'h00, 1'b1);
        check("post_rst_drain", 32'(data_empty), 1);

        // Random 50% strobes against a scoreboard queue
        for (int n = 0; n < 1000; n++) begin
            wr  = 1'($urandom_range(0, 1));
            rd  = 1'($urandom_range(0, 1));
            din = 8'($urandom);
            @(negedge clk);
            outport_wr = wr;
            outport    = din;
            data_rd    = rd;
            if (rd && q.size() != 0) begin
                check("rand_data", 32'(data), 32'(q[0]));
            end
            if (q.size() == DEPTH) wr = 1'b0;
            if (q.size() == 0) rd = 1'b0;
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(int'(din));
            @(posedge clk);
            #1;
            check("rand_count", 32'(count), 32'(q.size()));
        end
        @(negedge clk);
        outport_wr = 1'b0;
        data_rd    = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/outfifo_sync.md
Name: outfifo_sync

Overview:
- Processor-to-external byte FIFO peripheral for the 9x8 core; the transmit-direction counterpart of the inFIFO peripheral.
- Processor pushes bytes through an outport strobe and polls full/count through an inport.
- External logic in the same clock domain pops bytes from a first-word-fall-through output with an empty flag and a read strobe.

Parameters:
- DEPTH, 16, FIFO capacity in words including the output register; power of two, >= 4.
- DATA_WIDTH, 8, word width.
- CW, $clog2(DEPTH)+1, occupancy counter width (derived, localparam).

Ports:
- i_clk  input  1  processor/system clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_outport  input  DATA_WIDTH  byte written by the processor.
- i_outport_wr  input  1  processor write strobe, one cycle per byte.
- o_full  output  1  registered; high when count == DEPTH.
- o_count  output  CW  registered occupancy, 0..DEPTH.
- o_data  output  DATA_WIDTH  head-of-FIFO word; valid while o_data_empty is low.
- o_data_empty  output  1  registered; high when count == 0.
- i_data_rd  input  1  external pop strobe; consumes o_data this cycle.

Behaviour:
- Reset: asynchronous on i_rst_n low, released synchronously by the core reset tree. While reset is asserted:
  - o_full=0, o_count=0, o_data_empty=1, o_data=0.
  - Read/write pointers are 0 and the optional overflow flag is 0.
  - Memory contents are not reset.
- Reset mid-operation discards all stored data. The first write after release behaves as a write to an empty FIFO.
- Storage: output register plus a (DEPTH-1)-entry RAM with pointers that wrap modulo DEPTH-1 (use an explicit compare, since DEPTH-1 is not a power of two).
- Write, accepted when i_outport_wr=1 and o_full=0:
  - If the FIFO is empty, or count==1 with a simultaneous pop, the word goes directly to the output register.
  - Otherwise the word goes to the RAM.
- A write while o_full=1 is dropped, even if i_data_rd is high in the same cycle (full is evaluated on the registered flag). Sets the overflow flag when the optional feature is enabled.
- Read, accepted when i_data_rd=1 and o_data_empty=0:
  - The output register loads the RAM head if the RAM is non-empty.
  - If the RAM is empty, o_data holds its last value and o_data_empty rises next cycle.
- A read while empty is ignored, with no state change.
- Latency, write into empty FIFO at edge N: o_data valid and o_data_empty=0 after edge N (visible cycle N+1).
- Latency, pop: the next word is presented the cycle after the accepted pop.
- Counter:
  - count += 1 on an accepted write only.
  - count -= 1 on an accepted read only.
  - Unchanged on both or neither.
  - o_full and o_data_empty are registered decodes of the next count.
- Count never exceeds DEPTH and never underflows; wrap-around of both pointers is exercised every DEPTH-1 writes.

Optional Feature:
- Macro: OUTFIFO_SYNC_OVERFLOW_EN.
- When defined:
  - Adds output o_overflow (1 bit, reset 0).
  - Sticky, set by any dropped write.
  - Cleared by input i_overflow_clr (1 cycle strobe). Set wins over simultaneous clear.
- When undefined: neither port exists, and dropped writes are silent.

Decomposition:
- Shared package outfifo_pkg:
  - CW derivation function.
  - Default DEPTH and DATA_WIDTH constants.
  - Typedef for the occupancy count.
- One natural sub-module: outfifo_sync_ram, a simple dual-port register-file RAM with synchronous write and combinational read, (DEPTH-1) x DATA_WIDTH.
- Pointer, count and output-register logic stays in the top module.

Test Plan:
- Reset/idle:
  - Assert i_rst_n=0 mid-stream with count=5, then release.
  - Require o_count=0, o_data_empty=1, o_full=0 immediately (asynchronously).
  - The next write of 8'hA5 appears on o_data one cycle later.
- Burst fill, DEPTH=16:
  - Write 8'h01..8'h10 on 16 consecutive cycles, no reads.
  - o_full=1 after the 16th write, o_count=16.
  - A 17th write of 8'h11 is dropped (o_overflow=1 if enabled).
  - Draining yields 01..10 in order, then o_data_empty=1.
- FWFT latency: a single write of 8'h3C into an empty FIFO gives o_data=8'h3C and o_data_empty=0 on the next cycle; a pop gives o_data_empty=1 the cycle after.
- Simultaneous read/write:
  - At count=1, write 8'h77 while popping: count stays 1 and o_data=8'h77 next cycle.
  - At count=16, write plus pop: the write is dropped and count becomes 15.
- Wrap-around:
  - Random write/read strobes with a 50% duty cycle for 1000 cycles against a scoreboard queue.
  - Require an exact data order match; o_count always equals the scoreboard size.
- Empty read: pulse i_data_rd with o_data_empty=1; require no change to count, pointers or o_data.
